// File: rtl/topolar_cordic_mc.sv
`default_nettype none
// ============================================================================
//  Module      : topolar_cordic_mc
//  Description : Iterative rectangular-to-polar CORDIC (vectoring mode).
//                Accepts one signed (x,y) sample per transaction and returns
//                its magnitude, phase and channel tag. Output is held under
//                valid/ready back-pressure.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1          clock, rising edge
//    arstn    in   1          asynchronous active-low reset
//    i_vld    in   1          input sample valid
//    i_rdy    out  1          block can accept a sample (IDLE only)
//    i_x/i_y  in   DATA_W     signed real/imaginary part
//    i_ch     in   CH_W       channel tag, returned on o_ch
//    o_vld    out  1          result valid, held until accepted
//    o_ready  in   1          downstream accepts result
//    o_mag    out  DATA_W+1   unsigned magnitude
//    o_phase  out  PHASE_W    signed binary-angle phase, [-180,+180) deg
//    o_ch     out  CH_W       tag of the sample that produced this result
// ============================================================================
module topolar_cordic_mc #(
  parameter int DATA_W   = 32,
  parameter int PHASE_W  = 32,
  parameter int NSTAGES  = 16,
  parameter int CH_W     = 4,
  parameter int MAG_COMP = 1
) (
  input  logic               clk,
  input  logic               arstn,
  input  logic               i_vld,
  output logic               i_rdy,
  input  logic [DATA_W-1:0]  i_x,
  input  logic [DATA_W-1:0]  i_y,
  input  logic [CH_W-1:0]    i_ch,
  output logic               o_vld,
  input  logic               o_ready,
  output logic [DATA_W:0]    o_mag,
  output logic [PHASE_W-1:0] o_phase,
  output logic [CH_W-1:0]    o_ch
);

  // x/y carry DATA_W+2 integer bits (room for negating full scale and for
  // the ~1.65 CORDIC gain) plus fractional bits that absorb the truncation
  // of the shifted terms, keeping the magnitude accurate to about 1 LSB.
  localparam int          c_FRAC = 8;
  localparam int          c_IW   = DATA_W + 2 + c_FRAC;
  localparam int          c_MW   = DATA_W + 1;
  localparam logic [17:0] c_K    = 18'h26DD4;  // 0.607253 * 2^18

  localparam logic [PHASE_W-1:0] c_P90 = {2'b01, {(PHASE_W-2){1'b0}}};
  localparam logic [PHASE_W-1:0] c_M90 = {2'b11, {(PHASE_W-2){1'b0}}};

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_ITER = 2'd1;
  localparam logic [1:0] c_COMP = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;

  // round(atan(2^-i) / 2pi * 2^32)
  function automatic logic [31:0] f_atan32(input logic [4:0] idx);
    case (idx)
      5'd0:  f_atan32 = 32'h2000_0000;  5'd1:  f_atan32 = 32'h12E4_051E;
      5'd2:  f_atan32 = 32'h09FB_385B;  5'd3:  f_atan32 = 32'h0511_11D4;
      5'd4:  f_atan32 = 32'h028B_0D43;  5'd5:  f_atan32 = 32'h0145_D7E1;
      5'd6:  f_atan32 = 32'h00A2_F61E;  5'd7:  f_atan32 = 32'h0051_7C55;
      5'd8:  f_atan32 = 32'h0028_BE53;  5'd9:  f_atan32 = 32'h0014_5F2F;
      5'd10: f_atan32 = 32'h000A_2F98;  5'd11: f_atan32 = 32'h0005_17CC;
      5'd12: f_atan32 = 32'h0002_8BE6;  5'd13: f_atan32 = 32'h0001_45F3;
      5'd14: f_atan32 = 32'h0000_A2FA;  5'd15: f_atan32 = 32'h0000_517D;
      5'd16: f_atan32 = 32'h0000_28BE;  5'd17: f_atan32 = 32'h0000_145F;
      5'd18: f_atan32 = 32'h0000_0A30;  5'd19: f_atan32 = 32'h0000_0518;
      5'd20: f_atan32 = 32'h0000_028C;  5'd21: f_atan32 = 32'h0000_0146;
      5'd22: f_atan32 = 32'h0000_00A3;  5'd23: f_atan32 = 32'h0000_0051;
      5'd24: f_atan32 = 32'h0000_0029;  5'd25: f_atan32 = 32'h0000_0014;
      5'd26: f_atan32 = 32'h0000_000A;  5'd27: f_atan32 = 32'h0000_0005;
      5'd28: f_atan32 = 32'h0000_0003;  5'd29: f_atan32 = 32'h0000_0001;
      5'd30: f_atan32 = 32'h0000_0001;  default: f_atan32 = 32'h0000_0000;
    endcase
  endfunction

  logic [1:0]               r_state;
  logic [4:0]               r_cnt;
  logic signed [c_IW-1:0]   r_x, r_y;
  logic [PHASE_W-1:0]       r_z;
  logic [CH_W-1:0]          r_ch_s;
  logic                     r_zero;
  logic                     r_vld;
  logic [c_MW-1:0]          r_mag;
  logic [PHASE_W-1:0]       r_phase;
  logic [CH_W-1:0]          r_ch;

  logic signed [c_IW-1:0]   w_xe, w_ye, w_x0, w_y0;
  logic [PHASE_W-1:0]       w_z0;
  logic                     w_d, w_last, w_load;
  logic signed [c_IW-1:0]   w_xs, w_ys, w_x_nxt, w_y_nxt;
  logic [PHASE_W-1:0]       w_atan, w_z_nxt, w_fin_z;
  logic [c_IW-1:0]          w_mag_fx;
  logic [c_MW:0]            w_mag_int;
  logic [c_MW-1:0]          w_mag_sat;

  // Reset forces i_rdy low; it rises as soon as arstn releases in IDLE.
  assign i_rdy   = (r_state == c_IDLE) && arstn;
  assign o_vld   = r_vld;
  assign o_mag   = r_mag;
  assign o_phase = r_phase;
  assign o_ch    = r_ch;

  // Pre-rotation into the right half-plane so the iterations converge.
  assign w_xe = {{2{i_x[DATA_W-1]}}, i_x, {c_FRAC{1'b0}}};
  assign w_ye = {{2{i_y[DATA_W-1]}}, i_y, {c_FRAC{1'b0}}};

  always_comb begin
    w_x0 = w_xe;
    w_y0 = w_ye;
    w_z0 = '0;
    if (w_xe[c_IW-1]) begin
      if (!w_ye[c_IW-1]) begin
        w_x0 = w_ye;
        w_y0 = -w_xe;
        w_z0 = c_P90;
      end else begin
        w_x0 = -w_ye;
        w_y0 = w_xe;
        w_z0 = c_M90;
      end
    end
  end

  // One vectoring micro-rotation; z accumulates the angle removed from (x,y),
  // so it converges to the input phase.
  assign w_d     = r_y[c_IW-1];
  assign w_xs    = r_x >>> r_cnt;
  assign w_ys    = r_y >>> r_cnt;
  assign w_atan  = PHASE_W'(f_atan32(r_cnt) >> (32 - PHASE_W));
  assign w_x_nxt = w_d ? (r_x - w_ys) : (r_x + w_ys);
  assign w_y_nxt = w_d ? (r_y + w_xs) : (r_y - w_xs);
  assign w_z_nxt = w_d ? (r_z - w_atan) : (r_z + w_atan);
  assign w_last  = (r_cnt == 5'(NSTAGES - 1));

  generate
    if (MAG_COMP != 0) begin : g_comp
      logic [c_IW+17:0] w_prod;
      // x is never negative after pre-rotation, so an unsigned product is safe.
      assign w_prod   = (c_IW+18)'($unsigned(r_x)) * (c_IW+18)'(c_K);
      assign w_mag_fx = c_IW'(w_prod >> 18);
      assign w_fin_z  = r_z;
      assign w_load   = (r_state == c_COMP);
    end else begin : g_raw
      assign w_mag_fx = w_x_nxt;
      assign w_fin_z  = w_z_nxt;
      assign w_load   = (r_state == c_ITER) && w_last;
    end
  endgenerate

  assign w_mag_int = (c_MW+1)'(w_mag_fx >> c_FRAC);
  assign w_mag_sat = w_mag_int[c_MW] ? {c_MW{1'b1}} : w_mag_int[c_MW-1:0];

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_ch_s  <= '0;
      r_zero  <= 1'b0;
      r_vld   <= 1'b0;
      r_mag   <= '0;
      r_phase <= '0;
      r_ch    <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (i_vld) begin
            r_x     <= w_x0;
            r_y     <= w_y0;
            r_z     <= w_z0;
            r_ch_s  <= i_ch;
            r_zero  <= (i_x == '0) && (i_y == '0);
            r_cnt   <= '0;
            r_state <= c_ITER;
          end
        end
        c_ITER: begin
          r_x   <= w_x_nxt;
          r_y   <= w_y_nxt;
          r_z   <= w_z_nxt;
          r_cnt <= r_cnt + 5'd1;
          if (w_last) r_state <= (MAG_COMP != 0) ? c_COMP : c_DONE;
        end
        c_COMP: r_state <= c_DONE;
        default: begin
          if (o_ready) begin
            r_vld   <= 1'b0;
            r_state <= c_IDLE;
          end
        end
      endcase
      if (w_load) begin
        r_vld   <= 1'b1;
        r_mag   <= r_zero ? '0 : w_mag_sat;
        r_phase <= r_zero ? '0 : w_fin_z;
        r_ch    <= r_ch_s;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_topolar_cordic_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_topolar_cordic_mc
//  Description : Scoreboard bench for topolar_cordic_mc. Stimulus pushes the
//                hand-computed expected result; monitors pop and compare on
//                every output handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_topolar_cordic_mc;

  localparam int NST = 16;
  localparam int PTOL = 131072;  // 2^17 phase tolerance

  typedef struct {
    logic [32:0] mag;
    int          mag_tol;
    logic [31:0] ph;
    int          ph_tol;
    logic [3:0]  ch;
  } exp_t;

  logic        clk, arstn;
  logic        i_vld, i_rdy, o_vld, o_ready;
  logic [31:0] i_x, i_y, o_phase;
  logic [3:0]  i_ch, o_ch;
  logic [32:0] o_mag;

  logic        r_i_vld, r_i_rdy, r_o_vld, r_o_ready;
  logic [31:0] r_i_x, r_i_y, r_o_phase;
  logic [3:0]  r_i_ch, r_o_ch;
  logic [32:0] r_o_mag;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q_main[$];
  exp_t q_raw[$];
  exp_t e_m, e_r;

  topolar_cordic_mc #(.DATA_W(32), .PHASE_W(32), .NSTAGES(NST), .CH_W(4), .MAG_COMP(1)) u_dut (
    .clk(clk), .arstn(arstn), .i_vld(i_vld), .i_rdy(i_rdy), .i_x(i_x), .i_y(i_y),
    .i_ch(i_ch), .o_vld(o_vld), .o_ready(o_ready), .o_mag(o_mag), .o_phase(o_phase),
    .o_ch(o_ch));

  topolar_cordic_mc #(.DATA_W(32), .PHASE_W(32), .NSTAGES(NST), .CH_W(4), .MAG_COMP(0)) u_dut_raw (
    .clk(clk), .arstn(arstn), .i_vld(r_i_vld), .i_rdy(r_i_rdy), .i_x(r_i_x), .i_y(r_i_y),
    .i_ch(r_i_ch), .o_vld(r_o_vld), .o_ready(r_o_ready), .o_mag(r_o_mag),
    .o_phase(r_o_phase), .o_ch(r_o_ch));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic cmp_result(input string tag, input exp_t e, input logic [32:0] mag,
                            input logic [31:0] ph, input logic [3:0] ch);
    longint dm;
    int     dp;
    dm = longint'(mag) - longint'(e.mag);
    check({tag, "_mag"}, (dm <= e.mag_tol) && (dm >= -e.mag_tol), longint'(mag), longint'(e.mag));
    dp = $signed(ph - e.ph);
    check({tag, "_phase"}, (dp <= e.ph_tol) && (dp >= -e.ph_tol), $signed(ph), $signed(e.ph));
    check({tag, "_ch"}, ch == e.ch, ch, e.ch);
  endtask

  // Monitors: one comparison set per output handshake.
  always @(negedge clk) begin
    if (arstn && o_vld && o_ready) begin
      if (q_main.size() == 0) check("main_unexpected_output", 1'b0, o_mag, 0);
      else begin
        e_m = q_main.pop_front();
        cmp_result("main", e_m, o_mag, o_phase, o_ch);
      end
    end
  end

  always @(negedge clk) begin
    if (arstn && r_o_vld && r_o_ready) begin
      if (q_raw.size() == 0) check("raw_unexpected_output", 1'b0, r_o_mag, 0);
      else begin
        e_r = q_raw.pop_front();
        cmp_result("raw", e_r, r_o_mag, r_o_phase, r_o_ch);
      end
    end
  end

  task automatic send_main(input int x, input int y, input logic [3:0] ch, input bit push,
                           input logic [32:0] m, input int mt, input logic [31:0] p, input int pt);
    exp_t e;
    int   t = 0;
    while (!i_rdy && t < 100) begin @(posedge clk); #1; t++; end
    if (!i_rdy) check("main_send_timeout", 1'b0, 0, 1);
    if (push) begin
      e.mag = m; e.mag_tol = mt; e.ph = p; e.ph_tol = pt; e.ch = ch;
      q_main.push_back(e);
    end
    i_x = x; i_y = y; i_ch = ch; i_vld = 1'b1;
    @(posedge clk); #1;
    i_vld = 1'b0;
  endtask

  task automatic send_raw(input int x, input int y, input logic [3:0] ch,
                          input logic [32:0] m, input int mt, input logic [31:0] p, input int pt);
    exp_t e;
    int   t = 0;
    while (!r_i_rdy && t < 100) begin @(posedge clk); #1; t++; end
    if (!r_i_rdy) check("raw_send_timeout", 1'b0, 0, 1);
    e.mag = m; e.mag_tol = mt; e.ph = p; e.ph_tol = pt; e.ch = ch;
    q_raw.push_back(e);
    r_i_x = x; r_i_y = y; r_i_ch = ch; r_i_vld = 1'b1;
    @(posedge clk); #1;
    r_i_vld = 1'b0;
  endtask

  task automatic drain_main();
    int t = 0;
    while (q_main.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
    if (q_main.size() != 0) check("main_result_timeout", 1'b0, q_main.size(), 0);
  endtask

  task automatic drain_raw();
    int t = 0;
    while (q_raw.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
    if (q_raw.size() != 0) check("raw_result_timeout", 1'b0, q_raw.size(), 0);
  endtask

  // Quadrant sweep in units of 1024 with hand-computed magnitude / phase.
  int          vx [9] = '{ 1, 5, 1, -5, -1, -5, -1,  5,  1};
  int          vy [9] = '{ 1, 1, 5,  1,  5, -1, -5, -1, -5};
  logic [32:0] vm [9] = '{1448, 5221, 5221, 5221, 5221, 5221, 5221, 5221, 5221};
  int          vp [9] = '{ 536870912,  134932750,  938809074,  2012550898,  1208674574,
                          -2012550898, -1208674574, -134932750, -938809074};

  initial begin
    int lat;
    int ghost;
    arstn = 1'b0; i_vld = 1'b0; i_x = '0; i_y = '0; i_ch = '0; o_ready = 1'b1;
    r_i_vld = 1'b0; r_i_x = '0; r_i_y = '0; r_i_ch = '0; r_o_ready = 1'b1;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_vld", o_vld == 1'b0, o_vld, 0);
    check("rst_o_mag", o_mag == '0, o_mag, 0);
    check("rst_o_phase", o_phase == '0, o_phase, 0);
    check("rst_i_rdy_in_reset", i_rdy == 1'b0, i_rdy, 0);
    arstn = 1'b1;
    #1;
    check("rst_i_rdy_after_release", i_rdy == 1'b1, i_rdy, 1);

    // Quadrant sweep
    for (int i = 0; i < 9; i++) begin
      send_main(vx[i] * 1024, vy[i] * 1024, 4'(i), 1'b1, vm[i], 2, 32'(vp[i]), PTOL);
      drain_main();
    end

    // -180 deg wrap and latency
    send_main(-1024, 0, 4'h5, 1'b1, 33'd1024, 2, 32'h8000_0000, PTOL);
    lat = 0;
    while (!o_vld && lat < 40) begin @(posedge clk); #1; lat++; end
    check("latency_edges", lat == NST + 1, lat, NST + 1);
    drain_main();

    // Back-pressure
    o_ready = 1'b0;
    send_main(5120, -1024, 4'h6, 1'b1, 33'd5221, 2, -32'sd134932750, PTOL);
    lat = 0;
    while (!o_vld && lat < 40) begin @(posedge clk); #1; lat++; end
    check("bp_vld_rise", o_vld == 1'b1, o_vld, 1);
    for (int k = 0; k < 10; k++) begin
      if (k == 2) begin i_x = 7168; i_y = 2048; i_ch = 4'hF; i_vld = 1'b1; end
      check("bp_vld_held", o_vld == 1'b1, o_vld, 1);
      check("bp_i_rdy_low", i_rdy == 1'b0, i_rdy, 0);
      check("bp_mag_held", (o_mag >= 33'd5219) && (o_mag <= 33'd5223), o_mag, 5221);
      check("bp_ch_held", o_ch == 4'h6, o_ch, 6);
      @(posedge clk); #1;
    end
    i_vld = 1'b0;
    o_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_i_rdy_after_hs", i_rdy == 1'b1, i_rdy, 1);
    check("bp_vld_cleared", o_vld == 1'b0, o_vld, 0);
    check("bp_single_handshake", q_main.size() == 0, q_main.size(), 0);
    ghost = 0;
    repeat (25) begin @(posedge clk); #1; if (o_vld) ghost++; end
    check("bp_ignored_sample", ghost == 0, ghost, 0);

    // Channel tag and zero input
    send_main(0, 0, 4'hA, 1'b1, 33'd0, 0, 32'd0, 0);
    drain_main();
    send_main(3072, 4096, 4'h3, 1'b1, 33'd5120, 2, 32'd633866811, PTOL);
    drain_main();

    // Reset in the middle of a conversion
    send_main(5120, 1024, 4'h9, 1'b0, '0, 0, '0, 0);
    repeat (8) begin @(posedge clk); #1; end
    arstn = 1'b0;
    #1;
    check("mid_rst_i_rdy", i_rdy == 1'b0, i_rdy, 0);
    check("mid_rst_o_vld", o_vld == 1'b0, o_vld, 0);
    repeat (2) begin @(posedge clk); #1; end
    arstn = 1'b1;
    #1;
    check("mid_rst_i_rdy_release", i_rdy == 1'b1, i_rdy, 1);
    ghost = 0;
    repeat (30) begin @(posedge clk); #1; if (o_vld) ghost++; end
    check("mid_rst_no_stale", ghost == 0, ghost, 0);

    // Uncompensated gain
    send_raw(1024, 0, 4'h1, 33'd1686, 2, 32'd0, PTOL);
    drain_raw();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
